// File: rtl/u_lsu_dmem.sv
// u_lsu_dmem: data-memory responder for the execute stage load/store port.
//   Accepts one registered request per IDLE cycle. Writes update the enabled
//   byte lanes of a word-organised array. Reads return lsu_rd with a one-cycle
//   lsu_vld pulse WAIT+1 cycles after the request.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   lsu_a[31:0]       byte address
//   lsu_we[3:0]       byte-lane write enables (nonzero = write)
//   lsu_wd[31:0]      write data, lane i = bits 8i+7:8i
//   lsu_re[3:0]       byte-lane read enables (nonzero = read)
//   lsu_vld           read-data valid pulse
//   lsu_rd[31:0]      read data, held between pulses
//   lsu_busy          request stage must hold (multi-cycle read pending)
//   lsu_err           one-cycle pulse for an illegal request

// One byte lane of the array: synchronous write, asynchronous read.
module u_lsu_dmem_lane #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [AW-1:0] ra,
  output logic [7:0]    rd
);
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;

  assign rd = mem[ra];
endmodule

module u_lsu_dmem #(
  parameter int AW   = 10,
  parameter int WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lsu_a,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_wd,
  input  logic [3:0]  lsu_re,
  output logic        lsu_vld,
  output logic [31:0] lsu_rd,
  output logic        lsu_busy,
  output logic        lsu_err
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                              state;
  logic [3:0]                          cnt;
  logic [AW-1:0]                       idx, idx_q, ra;
  logic [NUM_LANES-1:0]                mask, re_q, re_sel;
  logic                                wr, rd, oor, mis, bad, bad_q, wr_go;
  logic [NUM_LANES-1:0][VEC_W-1:0]     wd_v, lane_rd, rdata;

  assign wr   = |lsu_we;
  assign rd   = |lsu_re;
  assign idx  = lsu_a[AW+1:2];
  assign mask = lsu_we | lsu_re;
  assign oor  = |(lsu_a >> (AW + 2));
  assign wd_v = lsu_wd;

  always_comb begin
    mis = 1'b0;
    case (mask)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: mis = 1'b0;
      4'b0011, 4'b1100:                            mis = lsu_a[0];
      4'b1111:                                     mis = |lsu_a[1:0];
      default:                                     mis = 1'b1;
    endcase
  end

  // A write/read conflict is illegal and is handled as a read returning 0.
  assign bad   = (wr & rd) | ((wr | rd) & (oor | mis));
  assign wr_go = (state == S_IDLE) & !rst & wr & !bad;

  // While waiting, the array is addressed from the latched request.
  assign ra     = (state == S_IDLE) ? idx : idx_q;
  assign re_sel = (state == S_IDLE) ? lsu_re : re_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    u_lsu_dmem_lane #(.AW(AW)) u_lane (
      .clk (clk),
      .we  (wr_go & lsu_we[g]),
      .wa  (idx),
      .wd  (wd_v[g]),
      .ra  (ra),
      .rd  (lane_rd[g])
    );
    assign rdata[g] = re_sel[g] ? lane_rd[g] : '0;
  end

  assign lsu_busy = !rst & ((state == S_WAIT) |
                            ((state == S_IDLE) & rd & (WAIT != 0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      lsu_vld <= 1'b0;
      lsu_rd  <= '0;
      lsu_err <= 1'b0;
      idx_q   <= '0;
      re_q    <= '0;
      bad_q   <= 1'b0;
    end else begin
      lsu_vld <= 1'b0;
      lsu_err <= 1'b0;
      case (state)
        S_IDLE: begin
          lsu_err <= bad;
          if (rd) begin
            if (WAIT == 0) begin
              lsu_vld <= 1'b1;
              lsu_rd  <= bad ? '0 : rdata;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT - 1);
              idx_q <= idx;
              re_q  <= lsu_re;
              bad_q <= bad;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state   <= S_IDLE;
            lsu_vld <= 1'b1;
            lsu_rd  <= bad_q ? '0 : rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_u_lsu_dmem.sv
// Directed bench for u_lsu_dmem: three instances (WAIT=0, 3, 2) with
// independent request inputs and a shared clock/reset.
module tb_u_lsu_dmem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   [3];
  logic [3:0]  we  [3];
  logic [31:0] wd  [3];
  logic [3:0]  re  [3];
  logic        vld [3];
  logic [31:0] rd  [3];
  logic        busy[3];
  logic        err [3];

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  u_lsu_dmem #(.AW(10), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .lsu_a(a[0]), .lsu_we(we[0]), .lsu_wd(wd[0]),
    .lsu_re(re[0]), .lsu_vld(vld[0]), .lsu_rd(rd[0]), .lsu_busy(busy[0]),
    .lsu_err(err[0]));
  u_lsu_dmem #(.AW(10), .WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .lsu_a(a[1]), .lsu_we(we[1]), .lsu_wd(wd[1]),
    .lsu_re(re[1]), .lsu_vld(vld[1]), .lsu_rd(rd[1]), .lsu_busy(busy[1]),
    .lsu_err(err[1]));
  u_lsu_dmem #(.AW(10), .WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .lsu_a(a[2]), .lsu_we(we[2]), .lsu_wd(wd[2]),
    .lsu_re(re[2]), .lsu_vld(vld[2]), .lsu_rd(rd[2]), .lsu_busy(busy[2]),
    .lsu_err(err[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and idle every request port.
  task automatic nxt();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      a[k] = '0; we[k] = '0; wd[k] = '0; re[k] = '0;
    end
    #1;
  endtask

  task automatic req(input int k, input logic [31:0] ad, input logic [3:0] w,
                     input logic [31:0] d, input logic [3:0] r);
    a[k] = ad; we[k] = w; wd[k] = d; re[k] = r;
    #1;
  endtask

  task automatic chk_rd(input string tag, input int k, input logic [31:0] exp);
    chk({tag, "_vld"}, {31'd0, vld[k]}, 32'd1);
    chk({tag, "_rd"}, rd[k], exp);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      a[k] = '0; we[k] = '0; wd[k] = '0; re[k] = '0;
    end
    // Reset: busy must stay low even with a read presented.
    @(posedge clk); #1;
    req(2, 32'h30, 4'h0, 32'h0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      chk("rst_vld",  {31'd0, vld[k]},  32'd0);
      chk("rst_rd",   rd[k],            32'd0);
      chk("rst_err",  {31'd0, err[k]},  32'd0);
      chk("rst_busy", {31'd0, busy[k]}, 32'd0);
    end
    nxt(); rst = 1'b0; #1;

    // WAIT=0 write then read-after-write.
    req(0, 32'h10, 4'hF, 32'hDEADBEEF, 4'h0);
    chk("w0_busy", {31'd0, busy[0]}, 32'd0);
    nxt(); req(0, 32'h10, 4'h0, 32'h0, 4'hF);
    chk("r0_busy", {31'd0, busy[0]}, 32'd0);
    chk("r0_novld", {31'd0, vld[0]}, 32'd0);
    nxt();
    chk_rd("raw", 0, 32'hDEADBEEF);
    chk("raw_err", {31'd0, err[0]}, 32'd0);
    req(0, 32'h0, 4'hF, 32'h01020304, 4'h0);
    nxt(); chk("vld_pulse", {31'd0, vld[0]}, 32'd0);
    req(0, 32'h4, 4'hF, 32'h55667788, 4'h0);
    nxt(); req(0, 32'h8, 4'hF, 32'h99AABBCC, 4'h0);

    // Byte lanes.
    nxt(); req(0, 32'h10, 4'hF, 32'h11223344, 4'h0);
    nxt(); req(0, 32'h12, 4'b1100, 32'hAABB0000, 4'h0);
    nxt(); req(0, 32'h10, 4'h0, 32'h0, 4'hF);
    chk("half_err", {31'd0, err[0]}, 32'd0);
    nxt(); req(0, 32'h10, 4'h0, 32'h0, 4'b0011);
    chk_rd("lane_full", 0, 32'hAABB3344);
    nxt();
    chk_rd("lane_lo", 0, 32'h00003344);

    // Misaligned read.
    req(0, 32'h11, 4'h0, 32'h0, 4'hF);
    nxt();
    chk("mis_err", {31'd0, err[0]}, 32'd1);
    chk_rd("mis", 0, 32'h0);
    // Out-of-range write (would alias idx 0).
    req(0, 32'h1000, 4'hF, 32'hCAFEF00D, 4'h0);
    nxt();
    chk("oor_err", {31'd0, err[0]}, 32'd1);
    chk("oor_novld", {31'd0, vld[0]}, 32'd0);
    // Write/read conflict.
    req(0, 32'h10, 4'hF, 32'h0BAD0BAD, 4'hF);
    nxt();
    chk("wr_rd_err", {31'd0, err[0]}, 32'd1);
    chk_rd("wr_rd", 0, 32'h0);
    nxt(); chk("err_pulse", {31'd0, err[0]}, 32'd0);

    // Consecutive reads 0x0, 0x4, 0x8 (also proves no illegal write landed).
    req(0, 32'h0, 4'h0, 32'h0, 4'hF);
    nxt(); req(0, 32'h4, 4'h0, 32'h0, 4'hF);
    chk_rd("b2b0", 0, 32'h01020304);
    nxt(); req(0, 32'h8, 4'h0, 32'h0, 4'hF);
    chk_rd("b2b1", 0, 32'h55667788);
    nxt(); req(0, 32'h10, 4'h0, 32'h0, 4'hF);
    chk_rd("b2b2", 0, 32'h99AABBCC);
    nxt();
    chk_rd("conflict_nowrite", 0, 32'hAABB3344);

    // WAIT=3 read with inputs changing during the wait.
    req(1, 32'h10, 4'hF, 32'hDEADBEEF, 4'h0);
    nxt(); req(1, 32'h20, 4'hF, 32'hAAAA5555, 4'h0);
    nxt(); req(1, 32'h10, 4'h0, 32'h0, 4'hF);
    chk("w3_c0_busy", {31'd0, busy[1]}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      nxt(); req(1, 32'h20, 4'hF, 32'h12345678, 4'h0);
      chk("w3_busy", {31'd0, busy[1]}, 32'd1);
      chk("w3_novld", {31'd0, vld[1]}, 32'd0);
    end
    nxt();
    chk("w3_c4_busy", {31'd0, busy[1]}, 32'd0);
    chk_rd("w3", 1, 32'hDEADBEEF);
    req(1, 32'h20, 4'h0, 32'h0, 4'hF);
    nxt(); nxt(); nxt();
    chk("w3_pend", {31'd0, vld[1]}, 32'd0);
    nxt();
    chk_rd("w3_ignored", 1, 32'hAAAA5555);

    // WAIT=2 read aborted by reset.
    nxt(); req(2, 32'h30, 4'hF, 32'h0BADCAFE, 4'h0);
    nxt(); req(2, 32'h30, 4'h0, 32'h0, 4'hF);
    chk("w2_c0_busy", {31'd0, busy[2]}, 32'd1);
    nxt(); rst = 1'b1; #1;
    chk("w2_rst_busy", {31'd0, busy[2]}, 32'd0);
    nxt(); rst = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      chk("w2_abort_vld",  {31'd0, vld[2]},  32'd0);
      chk("w2_abort_busy", {31'd0, busy[2]}, 32'd0);
      nxt();
    end
    req(2, 32'h30, 4'h0, 32'h0, 4'hF);
    nxt(); nxt();
    chk("w2_pend", {31'd0, vld[2]}, 32'd0);
    nxt();
    chk_rd("w2_after_rst", 2, 32'h0BADCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/u_lsu_dmem.md
Name: u_lsu_dmem

Overview:
- Data-memory responder for the execute stage's load/store request port.
- Receives the registered request bundle (lsu_a, lsu_we, lsu_wd, lsu_re) that the execute stage issues one pipe stage after address generation.
- Performs byte-lane writes into an internal word-organised array and returns load data as a one-cycle lsu_vld pulse with lsu_rd.
- Raises lsu_busy so the hazard unit holds the request stage while a multi-cycle read is pending.

Parameters:
- AW, 10, word-address width; the array holds 2^AW 32-bit words.
- WAIT, 0, extra read wait cycles (0..15).

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- rst  in  1  reset; one clock domain, synchronous, active-high.
- lsu_a  in  32  byte address of the request.
- lsu_we  in  4  byte-lane write enables; nonzero means a write request.
- lsu_wd  in  32  write data, lane i = bits 8i+7:8i.
- lsu_re  in  4  byte-lane read enables; nonzero means a read request.
- lsu_vld  out  1  read-data valid, one-cycle pulse.
- lsu_rd  out  32  read data, valid only while lsu_vld=1.
- lsu_busy  out  1  responder cannot accept; upstream must hold request inputs stable.
- lsu_err  out  1  one-cycle pulse flagging an illegal request.

Behaviour:
- Reset: state=IDLE, wait counter=0, lsu_vld=0, lsu_rd=0, lsu_err=0. lsu_busy=0 during the reset cycle. Array contents are not cleared. Reset mid-read aborts it: no lsu_vld is produced.
- Request decode: inputs are sampled only when state=IDLE and are ignored in WAIT.
  - wr = |lsu_we, rd = |lsu_re, idx = lsu_a[AW+1:2].
- Illegal request when any of these hold:
  - (wr & rd);
  - lsu_a[31:AW+2] != 0 (out of range);
  - misaligned: (any enabled lane mask other than 4'b0001/0010/0100/1000/0011/1100/1111) or (a 2-lane mask with lsu_a[0]!=0) or (a 4-lane mask with lsu_a[1:0]!=0).
  - An illegal request sets lsu_err=1 in the next cycle (one pulse). It performs no array write.
  - An illegal read still completes with normal timing and lsu_rd=0, so the pipeline never hangs.
  - An illegal write/read conflict (wr & rd) is treated as a read returning 0.
- Write (legal, IDLE): array[idx] lanes with lsu_we[i]=1 are updated at the end of that cycle; other lanes are unchanged. No lsu_vld and no lsu_busy. Back-to-back writes are accepted every cycle.
- Read (legal, IDLE), request in cycle c0:
  - lsu_busy=1 combinationally in c0 if WAIT>0, and stays 1 for cycles c0..c0+WAIT.
  - lsu_vld=1 and lsu_rd are registered in cycle c0+1+WAIT only.
  - Lanes with lsu_re[i]=0 read as 0.
  - Data reflects all writes accepted before c0.
- FSM:
  - IDLE -> WAIT on a read when WAIT>0, with counter loaded to WAIT-1. Otherwise a read stays in IDLE and the vld register is set.
  - WAIT: counter decrements each cycle. At 0 -> IDLE, with lsu_vld/lsu_rd set for the next cycle.
  - The cycle in which lsu_vld=1 is an IDLE cycle, so a new request (read or write) is accepted in that same cycle; back-to-back reads with WAIT=0 give one lsu_vld per cycle.
- Read-after-write: a write in c0 followed by a read of the same idx in c0+1 returns the new data.
- Outputs lsu_vld and lsu_err are 0 whenever not explicitly pulsed. lsu_rd holds its last value between pulses.

Test Plan:
- WAIT=0; write lsu_a=0x10, lsu_we=4'hF, lsu_wd=0xDEADBEEF in c0; read lsu_a=0x10, lsu_re=4'hF in c1 -> lsu_vld=1, lsu_rd=0xDEADBEEF in c2; lsu_busy never 1.
- WAIT=3; read 0x10 in c0, held -> lsu_busy=1 in c0..c3; lsu_vld=1, lsu_rd=0xDEADBEEF in c4 only. Input changes during c1..c3 are ignored.
- Byte lanes: array[4]=0x11223344; write lsu_a=0x12, lsu_we=4'b1100, lsu_wd=0xAABB0000 -> read 0x10 with re=4'hF returns 0xAABB3344; read with re=4'b0011 returns 0x00003344.
- Errors:
  - Read lsu_a=0x11, re=4'hF -> lsu_err=1 next cycle, lsu_vld=1, lsu_rd=0.
  - Write lsu_a=0x0000_1000 (AW=10, out of range) -> lsu_err=1 next cycle, no array change.
  - we=4'hF with re=4'hF -> lsu_err=1, read returns 0.
- WAIT=2; rst=1 in c1 of a pending read -> lsu_busy=0 and lsu_vld=0 from the following cycle, no vld ever. Afterwards a previously written word still reads back correctly.
- WAIT=0; reads of 0x0, 0x4, 0x8 in consecutive cycles -> three consecutive lsu_vld pulses with the matching data.
